branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, branch-history-table depth; power of two, at least 4.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port if_pc  in  XLEN  fetch PC for prediction lookup.
REQ-006 SHALL have port if_pred_taken  out  1  combinational prediction for if_pc.
REQ-007 SHALL have port ex_valid  in  1  resolve request this cycle.
REQ-008 SHALL have port ex_flush  in  1  kill the EX request this cycle.
REQ-009 SHALL have port ex_pc  in  XLEN  PC of the instruction being resolved.
REQ-010 SHALL have port A, B  in  XLEN each  signed comparison operands.
REQ-011 SHALL have port BrOp  in  5  branch opcode: [4] jump, [3] conditional branch, [2:0] funct3.
REQ-012 SHALL have port ex_pred_taken  in  1  prediction carried with the instruction.
REQ-013 SHALL have port res_valid  out  1  registered resolution strobe.
REQ-014 SHALL have port res_taken  out  1  registered actual outcome (NextPCSrc).
REQ-015 SHALL have port res_mispredict  out  1  registered mispredict, pipeline-flush request.

Function
REQ-016 SHALL index the table with ex_pc/if_pc bits [log2(BHT_ENTRIES)+1:2].
REQ-017 SHALL hold one 2-bit saturating counter per entry; if_pred_taken = counter[1] of the if_pc entry.
REQ-018 SHALL define an accepted request as ex_valid=1 and ex_flush=0; flush wins over valid.
REQ-019 SHALL compute taken for an accepted request: BrOp[4]=1 -> 1; else if BrOp[3]=1, funct3 000 A==B, 001 A!=B, 100 signed A<B, 101 signed A>=B, 110 unsigned A<B, 111 unsigned A>=B, 010/011 -> 0; else 0.
REQ-020 SHALL register res_valid=1, res_taken=taken, res_mispredict=(taken != ex_pred_taken) on the edge after acceptance; latency exactly 1 cycle.
REQ-021 SHALL drive res_valid=0, res_taken=0, res_mispredict=0 the cycle after any non-accepted cycle.
REQ-022 SHALL update the ex_pc counter on the accepting edge only when BrOp[4]=0, BrOp[3]=1 and funct3 is legal: taken -> increment saturating at 11, not taken -> decrement saturating at 00.
REQ-023 SHALL not update the table for jumps, non-branches, illegal funct3 or flushed requests.
REQ-024 SHALL return the pre-update value when if_pc and an accepting ex_pc share an index in the same cycle (no bypass).
REQ-025 SHALL perform all comparisons at full XLEN width with no truncation.

Reset
REQ-026 SHALL, while rst_n=0, immediately set every counter to 01 (weakly not-taken) and res_valid, res_taken, res_mispredict to 0, regardless of clock.
REQ-027 SHALL discard any request in flight when reset asserts mid-operation; first resolution after release depends only on post-release inputs.

Configuration
REQ-028 SHALL, with BPU_PERF_COUNTERS_EN defined, add outputs perf_branches and perf_mispredicts, 32 bits each, reset to 0 and incremented on each accepted conditional branch or jump (perf_branches) and each registered mispredict (perf_mispredicts), saturating at all-ones.
REQ-029 SHALL, without BPU_PERF_COUNTERS_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover reset: release rst_n, if_pc=any -> if_pred_taken=0; res_valid=0.
REQ-031 SHALL cover training: three accepted BEQ at ex_pc=0x100 with A=B=5 -> counter 01->10->11->11, if_pc=0x100 pred 1 after first; res_mispredict 1,0,0 when ex_pred_taken follows if_pred_taken.
REQ-032 SHALL cover signed vs unsigned: A=0xFFFFFFFF, B=1: BLT -> res_taken 1, BLTU -> 0, BGEU -> 1.
REQ-033 SHALL cover flush priority: ex_valid=1, ex_flush=1, BEQ taken -> next cycle res_valid=0, counter unchanged.
REQ-034 SHALL cover same-index collision: if_pc=ex_pc=0x200, counter 01, accepted taken BNE -> if_pred_taken=0 that cycle, 1 next cycle.
REQ-035 SHALL cover jump: BrOp=10000, ex_pred_taken=0 -> res_taken 1, res_mispredict 1, table unchanged; with BPU_PERF_COUNTERS_EN perf_branches=1, perf_mispredicts=1.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Branch resolution plus a bimodal predictor. The predictor is a table of
// 2-bit saturating counters indexed by PC bits [log2(BHT_ENTRIES)+1:2].
// The fetch stage reads the table combinationally (if_pred_taken). The
// execute stage resolves the branch, registers the outcome one cycle later
// and trains the counter of the resolved PC.
//
// Optional feature macro: BPU_PERF_COUNTERS_EN
//   When defined, the 32-bit saturating outputs perf_branches and
//   perf_mispredicts are added. When undefined, those ports and counters
//   do not exist and all other behaviour is the same.
//
// Request handshake: there is no ready signal. The unit always accepts.
// A request is accepted in any cycle where ex_valid=1 and ex_flush=0, and
// flush always wins over valid. Every accepted request produces exactly one
// res_valid pulse on the following cycle. A non-accepted cycle produces
// res_valid=0 with res_taken and res_mispredict forced to 0.

module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch-side lookup
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  // execute-side resolve request
  input  logic            ex_valid,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      BrOp,
  input  logic            ex_pred_taken,
  // registered resolution
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict
`ifdef BPU_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  // Branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Counter states
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // ------------------------------------------------------------------
  // Table indexing
  // ------------------------------------------------------------------
  logic [IDXW-1:0] if_idx;
  logic [IDXW-1:0] ex_idx;

  assign if_idx = if_pc[IDXW+1:2];
  assign ex_idx = ex_pc[IDXW+1:2];

  // The word-offset bits and the bits above the index do not take part in
  // the lookup. They are folded here so the intent is explicit.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDXW+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDXW+2], ex_pc[1:0]};

  // ------------------------------------------------------------------
  // Opcode decode
  // ------------------------------------------------------------------
  logic       is_jump;
  logic       is_cbr;
  logic [2:0] funct3;
  logic       f3_legal;
  logic       accept;

  // Split BrOp into jump / conditional-branch / funct3. Identify the legal branch encodings.
  always_comb begin
    is_jump  = BrOp[4];
    is_cbr   = ~BrOp[4] & BrOp[3];
    funct3   = BrOp[2:0];
    f3_legal = 1'b0;
    case (funct3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: f3_legal = 1'b1;
      default:                                          f3_legal = 1'b0;
    endcase
  end

  assign accept = ex_valid & ~ex_flush;

  // ------------------------------------------------------------------
  // Comparator. Every compare uses the full XLEN width.
  // ------------------------------------------------------------------
  logic eq;
  logic lt_s;
  logic lt_u;
  logic cond_taken;
  logic taken;

  // Evaluate the conditional-branch condition selected by funct3.
  always_comb begin
    eq         = (A == B);
    lt_s       = ($signed(A) < $signed(B));
    lt_u       = (A < B);
    cond_taken = 1'b0;
    case (funct3)
      F3_BEQ:  cond_taken = eq;
      F3_BNE:  cond_taken = ~eq;
      F3_BLT:  cond_taken = lt_s;
      F3_BGE:  cond_taken = ~lt_s;
      F3_BLTU: cond_taken = lt_u;
      F3_BGEU: cond_taken = ~lt_u;
      default: cond_taken = 1'b0;
    endcase
  end

  // Actual outcome. A jump is always taken. A non-branch is never taken.
  always_comb begin
    if (is_jump)      taken = 1'b1;
    else if (BrOp[3]) taken = cond_taken;
    else              taken = 1'b0;
  end

  // ------------------------------------------------------------------
  // Counter training
  // ------------------------------------------------------------------
  logic       upd_en;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_next;

  // Only accepted conditional branches with a legal funct3 train the table.
  // Jumps, non-branches, illegal encodings and flushed requests do not.
  assign upd_en  = accept & is_cbr & f3_legal;

  // Saturating increment on taken and saturating decrement on not-taken.
  always_comb begin
    ctr_next = ctr_cur;
    if (cond_taken) begin
      if (ctr_cur != CTR_ST)  ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != CTR_SNT) ctr_next = ctr_cur - 2'b01;
    end
  end

  // ------------------------------------------------------------------
  // Branch history table
  // ------------------------------------------------------------------
  logic [1:0] bht [BHT_ENTRIES];

  assign ctr_cur = bht[ex_idx];

  // Reset every counter to weakly-not-taken. After reset, write back the
  // trained counter of the resolved PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_WNT;
      end
    end else if (upd_en) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // The lookup reads the stored array directly. A same-cycle update to the
  // same index is therefore seen only from the next cycle onward.
  assign if_pred_taken = bht[if_idx][1];

  // ------------------------------------------------------------------
  // Registered resolution
  // ------------------------------------------------------------------
  logic mispredict;

  assign mispredict = taken ^ ex_pred_taken;

  // Register the outcome one cycle after acceptance. Outputs are forced to 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
    end else begin
      res_valid      <= accept;
      res_taken      <= accept & taken;
      res_mispredict <= accept & mispredict;
    end
  end

`ifdef BPU_PERF_COUNTERS_EN
  // ------------------------------------------------------------------
  // Performance counters. They saturate at all-ones instead of wrapping.
  // ------------------------------------------------------------------
  logic count_branch;
  logic count_mispredict;

  // perf_branches counts any accepted conditional branch or jump.
  // perf_mispredicts moves on the same edge that registers res_mispredict=1.
  assign count_branch     = accept & (is_jump | is_cbr);
  assign count_mispredict = accept & mispredict;

  // Count accepted branches and registered mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (count_branch && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (count_mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit (XLEN=32, BHT_ENTRIES=64).
// Inputs change on the falling edge. The combinational prediction is
// sampled just after the inputs change. Registered results are sampled 1ns
// after the rising edge. Every expected value is hand-derived.
// With the default table depth, PCs 0x100, 0x200, 0x400, 0x500, 0x600 and
// 0x700 all map to index 0. For that reason each scenario starts from reset.

module tb_branch_predict_unit;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_JUMP = 5'b10000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BIL  = 5'b01010;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BGE  = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_flush;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [4:0]      BrOp;
  logic            ex_pred_taken;
  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;
`ifdef BPU_PERF_COUNTERS_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;
`endif

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_flush       (ex_flush),
    .ex_pc          (ex_pc),
    .A              (A),
    .B              (B),
    .BrOp           (BrOp),
    .ex_pred_taken  (ex_pred_taken),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict)
`ifdef BPU_PERF_COUNTERS_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ex_valid = 1'b0; ex_flush = 1'b0; ex_pc = '0; A = '0; B = '0;
    BrOp = OP_NONE; ex_pred_taken = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one request on the falling edge and settle the combinational paths.
  task automatic drive_req(input logic v, input logic f, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] op, input logic pt);
    @(negedge clk);
    ex_valid = v; ex_flush = f; ex_pc = pc; A = a; B = b; BrOp = op; ex_pred_taken = pt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [XLEN-1:0] pcs [3];
    pcs[0] = 32'h0000_0000; pcs[1] = 32'h0000_0104; pcs[2] = 32'h0000_00FC;
    idle_inputs();
    if_pc = 32'h100;
    rst_n = 1'b0;
    #3;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold res_valid got %b exp 0", res_valid); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_hold pred got %b exp 0", if_pred_taken); end
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      if_pc = pcs[i];
      tick();
      n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred[%0d] got %b exp 0", i, if_pred_taken); end
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid[%0d] got %b exp 0", i, res_valid); end
    end
  endtask

  task automatic test_training();
    logic pred_e [3];
    logic mis_e  [3];
    pred_e[0] = 1'b0; pred_e[1] = 1'b1; pred_e[2] = 1'b1;
    mis_e[0]  = 1'b1; mis_e[1]  = 1'b0; mis_e[2]  = 1'b0;
    apply_reset();
    if_pc = 32'h100;
    // Three taken BEQs: 01 -> 10 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 1'b0, 32'h100, 32'd5, 32'd5, OP_BEQ, pred_e[i]);
      n_checks++; if (if_pred_taken !== pred_e[i]) begin n_fail++; $display("FAIL train_pred[%0d] got %b exp %b", i, if_pred_taken, pred_e[i]); end
      tick();
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL train_valid[%0d] got %b exp 1", i, res_valid); end
      n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL train_taken[%0d] got %b exp 1", i, res_taken); end
      n_checks++; if (res_mispredict !== mis_e[i]) begin n_fail++; $display("FAIL train_mis[%0d] got %b exp %b", i, res_mispredict, mis_e[i]); end
    end
    // Two not-taken BEQs: 11 -> 10 (still predicts taken) -> 01 (not taken).
    drive_req(1'b1, 1'b0, 32'h100, 32'd5, 32'd6, OP_BEQ, 1'b1);
    tick();
    n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL train_nt_mis got %b exp 1", res_mispredict); end
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_sat11 pred got %b exp 1", if_pred_taken); end
    drive_req(1'b1, 1'b0, 32'h100, 32'd5, 32'd6, OP_BEQ, 1'b1);
    tick();
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_back01 pred got %b exp 0", if_pred_taken); end
  endtask

  task automatic test_signed_unsigned();
    logic [4:0]      op  [8];
    logic [XLEN-1:0] va  [8];
    logic [XLEN-1:0] vb  [8];
    logic            exp [8];
    op[0] = OP_BLT;  va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;          exp[0] = 1'b1;
    op[1] = OP_BLTU; va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;          exp[1] = 1'b0;
    op[2] = OP_BGEU; va[2] = 32'hFFFF_FFFF; vb[2] = 32'd1;          exp[2] = 1'b1;
    op[3] = OP_BGE;  va[3] = 32'hFFFF_FFFF; vb[3] = 32'd1;          exp[3] = 1'b0;
    op[4] = OP_BNE;  va[4] = 32'h8000_0000; vb[4] = 32'd0;          exp[4] = 1'b1;
    op[5] = OP_BEQ;  va[5] = 32'h8000_0001; vb[5] = 32'd1;          exp[5] = 1'b0;
    op[6] = OP_BLT;  va[6] = 32'h7FFF_FFFF; vb[6] = 32'h8000_0000; exp[6] = 1'b0;
    op[7] = OP_BLTU; va[7] = 32'h7FFF_FFFF; vb[7] = 32'h8000_0000; exp[7] = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b1, 1'b0, 32'h300 + 32'(i * 4), va[i], vb[i], op[i], 1'b0);
      tick();
      n_checks++; if (res_taken !== exp[i]) begin n_fail++; $display("FAIL cmp_taken[%0d] got %b exp %b", i, res_taken, exp[i]); end
      n_checks++; if (res_mispredict !== exp[i]) begin n_fail++; $display("FAIL cmp_mis[%0d] got %b exp %b", i, res_mispredict, exp[i]); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    if_pc = 32'h400;
    drive_req(1'b1, 1'b1, 32'h400, 32'd7, 32'd7, OP_BEQ, 1'b0);
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL flush_taken got %b exp 0", res_taken); end
    n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL flush_mis got %b exp 0", res_mispredict); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL flush_pred got %b exp 0", if_pred_taken); end
    // If the counter is still 01, one taken branch makes it predict taken.
    drive_req(1'b1, 1'b0, 32'h400, 32'd7, 32'd7, OP_BEQ, 1'b0);
    tick();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after_valid got %b exp 1", res_valid); end
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL flush_after_pred got %b exp 1", if_pred_taken); end
  endtask

  task automatic test_collision();
    apply_reset();
    if_pc = 32'h200;
    drive_req(1'b1, 1'b0, 32'h200, 32'd1, 32'd2, OP_BNE, 1'b0);
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL collide_same got %b exp 0", if_pred_taken); end
    tick();
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL collide_taken got %b exp 1", res_taken); end
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL collide_next got %b exp 1", if_pred_taken); end
  endtask

  task automatic test_jump();
    apply_reset();
    if_pc = 32'h500;
    drive_req(1'b1, 1'b0, 32'h500, 32'd0, 32'd0, OP_JUMP, 1'b0);
    tick();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL jump_valid got %b exp 1", res_valid); end
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL jump_taken got %b exp 1", res_taken); end
    n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL jump_mis got %b exp 1", res_mispredict); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL jump_table got %b exp 0", if_pred_taken); end
`ifdef BPU_PERF_COUNTERS_EN
    n_checks++; if (perf_branches !== 32'd1) begin n_fail++; $display("FAIL perf_branches got %0d exp 1", perf_branches); end
    n_checks++; if (perf_mispredicts !== 32'd1) begin n_fail++; $display("FAIL perf_mispredicts got %0d exp 1", perf_mispredicts); end
`endif
    // The jump bit overrides the branch bits (BEQ with A!=B) and still does not train.
    drive_req(1'b1, 1'b0, 32'h500, 32'd1, 32'd2, 5'b11000, 1'b1);
    tick();
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL jump_over_taken got %b exp 1", res_taken); end
    n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL jump_over_mis got %b exp 0", res_mispredict); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL jump_over_table got %b exp 0", if_pred_taken); end
  endtask

  task automatic test_no_update();
    apply_reset();
    if_pc = 32'h600;
    drive_req(1'b1, 1'b0, 32'h600, 32'd3, 32'd3, OP_NONE, 1'b1);
    tick();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL nonbr_valid got %b exp 1", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL nonbr_taken got %b exp 0", res_taken); end
    n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL nonbr_mis got %b exp 1", res_mispredict); end
    drive_req(1'b1, 1'b0, 32'h600, 32'd3, 32'd3, OP_BIL, 1'b0);
    tick();
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL illegal_taken got %b exp 0", res_taken); end
    n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL illegal_mis got %b exp 0", res_mispredict); end
    drive_req(1'b0, 1'b0, 32'h600, 32'd3, 32'd3, OP_BEQ, 1'b1);
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL idle_taken got %b exp 0", res_taken); end
    n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL idle_mis got %b exp 0", res_mispredict); end
    // The counter should still be 01, so one taken BEQ flips the prediction.
    drive_req(1'b1, 1'b0, 32'h600, 32'd3, 32'd3, OP_BEQ, 1'b0);
    tick();
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL noupd_pred got %b exp 1", if_pred_taken); end
  endtask

  task automatic test_index();
    logic [XLEN-1:0] pcs [5];
    logic            exp [5];
    pcs[0] = 32'h104; exp[0] = 1'b1;
    pcs[1] = 32'h504; exp[1] = 1'b1;
    pcs[2] = 32'h107; exp[2] = 1'b1;
    pcs[3] = 32'h108; exp[3] = 1'b0;
    pcs[4] = 32'h100; exp[4] = 1'b0;
    apply_reset();
    drive_req(1'b1, 1'b0, 32'h104, 32'd9, 32'd9, OP_BEQ, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if_pc = pcs[i];
      #1;
      n_checks++; if (if_pred_taken !== exp[i]) begin n_fail++; $display("FAIL index[%0d] pc %h got %b exp %b", i, pcs[i], if_pred_taken, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] vb     [5];
    logic            pred_e [5];
    logic            tk_e   [5];
    logic            mis_e  [5];
    // The counter steps through 01 -> 00 -> 00 -> 01 -> 10 -> 11.
    vb[0] = 32'd4; pred_e[0] = 1'b0; tk_e[0] = 1'b0; mis_e[0] = 1'b0;
    vb[1] = 32'd4; pred_e[1] = 1'b0; tk_e[1] = 1'b0; mis_e[1] = 1'b0;
    vb[2] = 32'd5; pred_e[2] = 1'b0; tk_e[2] = 1'b1; mis_e[2] = 1'b1;
    vb[3] = 32'd5; pred_e[3] = 1'b0; tk_e[3] = 1'b1; mis_e[3] = 1'b1;
    vb[4] = 32'd5; pred_e[4] = 1'b1; tk_e[4] = 1'b1; mis_e[4] = 1'b0;
    apply_reset();
    if_pc = 32'h700;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, 1'b0, 32'h700, 32'd4, vb[i], OP_BNE, pred_e[i]);
      n_checks++; if (if_pred_taken !== pred_e[i]) begin n_fail++; $display("FAIL b2b_pred[%0d] got %b exp %b", i, if_pred_taken, pred_e[i]); end
      tick();
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, res_valid); end
      n_checks++; if (res_taken !== tk_e[i]) begin n_fail++; $display("FAIL b2b_taken[%0d] got %b exp %b", i, res_taken, tk_e[i]); end
      n_checks++; if (res_mispredict !== mis_e[i]) begin n_fail++; $display("FAIL b2b_mis[%0d] got %b exp %b", i, res_mispredict, mis_e[i]); end
    end
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_final got %b exp 1", if_pred_taken); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    if_pc = 32'h100;
    drive_req(1'b1, 1'b0, 32'h100, 32'd1, 32'd1, OP_BEQ, 1'b0);
    tick();
    drive_req(1'b1, 1'b0, 32'h100, 32'd1, 32'd1, OP_BEQ, 1'b1);
    tick();
    // A taken request is in flight when reset asserts asynchronously.
    drive_req(1'b1, 1'b0, 32'h100, 32'd1, 32'd2, OP_BNE, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", res_valid); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_table got %b exp 0", if_pred_taken); end
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_edge_valid got %b exp 0", res_valid); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_post_valid got %b exp 0", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_post_taken got %b exp 0", res_taken); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_post_pred got %b exp 0", if_pred_taken); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    if_pc = '0;
    test_reset();
    test_training();
    test_signed_unsigned();
    test_flush();
    test_collision();
    test_jump();
    test_no_update();
    test_index();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
